// File: rtl/subway_out_sequencer.sv
// Output-side move sequencer: buffers planner moves for one frame and replays them
// as a single contiguous out_valid burst, with an output-latency watchdog.
module subway_out_sequencer #(
    parameter int unsigned NUM_MOVES = 63,
    parameter int unsigned TIMEOUT   = 3000,
    parameter int unsigned CNT_W     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       mv_valid,
    input  logic [1:0] mv_data,
    output logic       mv_ready,
    output logic       out_valid,
    output logic [1:0] out,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned PTR_W = 6;
    localparam int unsigned DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] lat_cnt;
    logic [1:0]       move_mem [DEPTH];

    logic             accept;
    logic             last_accept;
    logic             lat_expire;
    logic             go_emit;
    logic             go_hold;
    logic [1:0]       first_move;
    logic [1:0]       next_move;

    // Handshake, transition qualifiers and buffer read paths
    always_comb begin
        mv_ready    = (state == COLLECT) && (wr_ptr < PTR_W'(NUM_MOVES));
        accept      = mv_valid && mv_ready;
        last_accept = accept && (wr_ptr == PTR_W'(NUM_MOVES - 1));
        lat_expire  = !in_valid && (lat_cnt == CNT_W'(TIMEOUT - 1));
        go_emit     = ((state == COLLECT) && last_accept && !in_valid) ||
                      ((state == HOLD) && !in_valid);
        go_hold     = (state == COLLECT) && last_accept && in_valid;
        // Forward the incoming move when slot 0 is written on the same edge
        first_move  = (accept && (wr_ptr == '0)) ? mv_data : move_mem[0];
        next_move   = move_mem[rd_ptr + PTR_W'(1)];
    end

    // Move buffer; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            move_mem[wr_ptr] <= mv_data;
        end
    end

    // Frame FSM with registered pin outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lat_cnt   <= '0;
            out_valid <= 1'b0;
            out       <= 2'd0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= COLLECT;
                        busy    <= 1'b1;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        lat_cnt <= '0;
                    end
                end
                COLLECT, HOLD: begin
                    lat_cnt <= in_valid ? '0 : lat_cnt + CNT_W'(1);
                    // A final handshake wins over a coincident watchdog expiry
                    if (go_emit) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out       <= first_move;
                        rd_ptr    <= '0;
                    end else if (go_hold) begin
                        state <= HOLD;
                    end else if (lat_expire) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                EMIT: begin
                    // in_valid is deliberately ignored here
                    if (rd_ptr == PTR_W'(NUM_MOVES - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out       <= 2'd0;
                    end else begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                        out    <= next_move;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subway_out_sequencer.sv
// Randomized bench for subway_out_sequencer: frames are driven, every cycle is logged,
// and the log is compared against a timeline derived from the handshake/in_valid times.
module tb_subway_out_sequencer;

    localparam int NUM_MOVES = 63;
    localparam int TIMEOUT   = 3000;
    localparam int LOG_N     = 16384;

    localparam int M_PATTERN = 0;
    localparam int M_GAP     = 1;
    localparam int M_RANDOM  = 2;
    localparam int M_STEADY  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       mv_valid;
    logic [1:0] mv_data;
    logic       mv_ready;
    logic       out_valid;
    logic [1:0] out;
    logic       busy;
    logic       timeout;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    bit       ov_l   [LOG_N];
    bit [1:0] out_l  [LOG_N];
    bit       to_l   [LOG_N];
    bit       busy_l [LOG_N];
    bit       rdy_l  [LOG_N];

    int       t0;
    int       f;
    int       c_last;
    logic [1:0] sent[$];

    subway_out_sequencer #(
        .NUM_MOVES(63),
        .TIMEOUT  (3000),
        .CNT_W    (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .mv_valid (mv_valid),
        .mv_data  (mv_data),
        .mv_ready (mv_ready),
        .out_valid(out_valid),
        .out      (out),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            ov_l[cyc]   = out_valid;
            out_l[cyc]  = out;
            to_l[cyc]   = timeout;
            busy_l[cyc] = busy;
            rdy_l[cyc]  = mv_ready;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pick(input int mode, input int idx);
        if (mode == M_PATTERN) return 2'(idx % 4);
        return 2'($urandom_range(0, 3));
    endfunction

    task automatic drive_in_valid(input int n);
        in_valid = 1'b1;
        t0 = cyc;
        repeat (n) tick();
        in_valid = 1'b0;
        f = cyc;
    endtask

    task automatic planner(input int mode, input int nmoves, input int delay);
        int i;
        int phase;
        int budget;
        logic [1:0] cur;
        i = 0;
        phase = 0;
        budget = 1000;
        cur = pick(mode, 0);
        repeat (delay) tick();
        while (i < nmoves && budget > 0) begin
            case (mode)
                M_GAP:    mv_valid = (phase % 4 == 0);
                M_RANDOM: mv_valid = ($urandom_range(0, 2) != 0);
                default:  mv_valid = 1'b1;
            endcase
            mv_data = cur;
            @(negedge clk);
            if (mv_valid && mv_ready) begin
                sent.push_back(cur);
                c_last = cyc;
                i++;
                cur = pick(mode, i);
            end
            @(posedge clk);
            #1;
            phase++;
            budget--;
        end
        mv_valid = 1'b0;
        mv_data  = 2'd0;
        check("moves_accepted", i, nmoves);
    endtask

    // One frame: 64-cycle in_valid strobe plus planner; optional protocol-error
    // pulse during the burst, or a reset at burst cycle reset_at.
    task automatic run_frame(input int mode, input int nmoves, input int delay,
                             input bit inject, input int reset_at);
        bit full;
        int start;
        int wend;
        int k;
        int exp_ov;
        int exp_out;
        int exp_to;
        int exp_busy;
        int exp_rdy;
        sent.delete();
        c_last = -1;
        fork
            drive_in_valid(64);
            planner(mode, nmoves, delay);
        join
        full  = (nmoves == NUM_MOVES);
        start = ((c_last > f) ? c_last : f) + 1;
        if (!full) begin
            wend = f + TIMEOUT + 1;
        end else if (reset_at >= 0) begin
            wend = start + reset_at - 1;
        end else begin
            wend = start + NUM_MOVES + 1;
        end

        if (full && inject) begin
            while (cyc < start + 10) tick();
            in_valid = 1'b1;
            repeat (5) tick();
            in_valid = 1'b0;
        end

        if (full && reset_at >= 0) begin
            while (cyc < start + reset_at) tick();
            check("pre_rst_ov", 32'(out_valid), 1);
            #2;
            rst = 1'b1;
            #1;
            check("async_rst_ov", 32'(out_valid), 0);
            check("async_rst_out", 32'(out), 0);
            check("async_rst_busy", 32'(busy), 0);
            repeat (2) tick();
            rst = 1'b0;
            @(negedge clk);
            check("rel_ov", 32'(out_valid), 0);
            check("rel_out", 32'(out), 0);
            check("rel_rdy", 32'(mv_ready), 0);
            check("rel_busy", 32'(busy), 0);
            tick();
        end

        while (cyc < wend + 1) tick();

        for (int t = t0; t <= wend && t < LOG_N; t++) begin
            k        = t - start;
            exp_ov   = (full && t >= start && t < start + NUM_MOVES) ? 1 : 0;
            exp_out  = (exp_ov != 0 && k < sent.size()) ? int'(sent[k]) : 0;
            exp_to   = (!full && t == f + TIMEOUT) ? 1 : 0;
            exp_busy = (t > t0 && (full ? (t < start + NUM_MOVES) : (t < f + TIMEOUT))) ? 1 : 0;
            exp_rdy  = (t > t0 && t <= (full ? c_last : (f + TIMEOUT - 1))) ? 1 : 0;
            check($sformatf("out_valid@%0d", t), 32'(ov_l[t]), exp_ov);
            check($sformatf("out@%0d", t), 32'(out_l[t]), exp_out);
            check($sformatf("timeout@%0d", t), 32'(to_l[t]), exp_to);
            check($sformatf("busy@%0d", t), 32'(busy_l[t]), exp_busy);
            check($sformatf("mv_ready@%0d", t), 32'(rdy_l[t]), exp_rdy);
        end
        repeat ($urandom_range(1, 5)) tick();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        mv_valid = 1'b0;
        mv_data  = 2'd0;
        @(negedge clk);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_out", 32'(out), 0);
        check("rst_rdy", 32'(mv_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("first_ov", 32'(out_valid), 0);
        check("first_out", 32'(out), 0);
        check("first_rdy", 32'(mv_ready), 0);
        check("first_busy", 32'(busy), 0);
        tick();

        run_frame(M_PATTERN, 63, 64, 1'b0, -1);
        run_frame(M_STEADY, 63, 0, 1'b0, -1);
        run_frame(M_GAP, 63, 20, 1'b0, -1);
        run_frame(M_STEADY, 10, 64, 1'b0, -1);
        run_frame(M_PATTERN, 63, 64, 1'b0, -1);
        for (int r = 0; r < 4; r++) begin
            run_frame(M_RANDOM, 63, $urandom_range(0, 90), 1'b0, -1);
        end
        run_frame(M_RANDOM, 63, $urandom_range(0, 90), 1'b1, -1);
        run_frame(M_STEADY, 63, 64, 1'b0, 20);
        run_frame(M_STEADY, 63, 64, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
